// File: rtl/signed_max_seq.sv
// Streaming signed maximum: finds the largest element of each COUNT-element frame and its index.
// Optional macro SIGNED_MAX_TIE_LAST_EN makes ties select the latest index instead of the earliest.
module signed_max_seq #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O_MAX,
  output logic [IDX_W-1:0] O_IDX
);

  typedef enum logic {ACCEPT = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [WIDTH-1:0] max_q;
  logic [IDX_W-1:0] idx_q;

  logic             in_hs;
  logic             last;
  logic [WIDTH-1:0] diff;
  logic             sign_differs;
  logic             max_lt;
  logic             max_eq;
  logic             take;

  assign in_hs = (state_q == ACCEPT) && I_VALID;
  assign last  = (cnt_q == IDX_W'(COUNT - 1));

  // One shared subtract; when operand signs differ the subtract may overflow,
  // so the negative operand is simply the smaller one.
  assign diff         = max_q - I_DATA;
  assign sign_differs = max_q[WIDTH-1] ^ I_DATA[WIDTH-1];
  assign max_lt       = sign_differs ? max_q[WIDTH-1] : diff[WIDTH-1];
  assign max_eq       = (diff == '0);

`ifdef SIGNED_MAX_TIE_LAST_EN
  assign take = max_lt | max_eq;
`else
  assign take = max_lt;
`endif

  always_comb begin
    state_d = state_q;
    I_READY = 1'b0;
    O_VALID = 1'b0;
    case (state_q)
      ACCEPT: begin
        I_READY = 1'b1;
        if (I_VALID && last) state_d = DONE;
      end
      DONE: begin
        O_VALID = 1'b1;
        if (O_READY) state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // The first element of a frame always loads, regardless of the old maximum.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ACCEPT;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        cnt_q <= last ? '0 : cnt_q + IDX_W'(1);
        if ((cnt_q == '0) || take) begin
          max_q <= I_DATA;
          idx_q <= cnt_q;
        end
      end
    end
  end

  assign O_MAX = max_q;
  assign O_IDX = idx_q;

endmodule

// File: tb/tb_signed_max_seq.sv
// Directed, table-driven bench for signed_max_seq: frame table, backpressure,
// bubbles/reset, COUNT=1 frames and an exhaustive WIDTH=4 compare sweep.
module tb_signed_max_seq;

`ifdef SIGNED_MAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;

  logic       i_valid, i_ready, o_valid, o_ready;
  logic [7:0] i_data, o_max;
  logic [1:0] o_idx;

  logic       v1, r1, ov1, ordy1;
  logic [7:0] d1, max1;
  logic [0:0] idx1;

  logic       v4, r4, ov4, ordy4;
  logic [3:0] d4, max4;
  logic [0:0] idx4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signed_max_seq #(.WIDTH(8), .COUNT(4)) dut (
    .CLK(clk), .RESET(reset), .I_VALID(i_valid), .I_READY(i_ready), .I_DATA(i_data),
    .O_VALID(o_valid), .O_READY(o_ready), .O_MAX(o_max), .O_IDX(o_idx)
  );

  signed_max_seq #(.WIDTH(8), .COUNT(1)) dut1 (
    .CLK(clk), .RESET(reset), .I_VALID(v1), .I_READY(r1), .I_DATA(d1),
    .O_VALID(ov1), .O_READY(ordy1), .O_MAX(max1), .O_IDX(idx1)
  );

  signed_max_seq #(.WIDTH(4), .COUNT(2)) dut4 (
    .CLK(clk), .RESET(reset), .I_VALID(v4), .I_READY(r4), .I_DATA(d4),
    .O_VALID(ov4), .O_READY(ordy4), .O_MAX(max4), .O_IDX(idx4)
  );

  typedef struct {
    string      name;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] exp_max;
    logic [1:0] exp_idx;
  } frame_t;

  frame_t frames [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one element to the main DUT and return just after it is accepted.
  task automatic applyStimulus(input logic [7:0] d);
    int waited;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    waited  = 0;
    while (!i_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!i_ready) begin
      checkOutput("accept_timeout", 32'(i_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic runFrame(input frame_t f);
    applyStimulus(f.d0);
    applyStimulus(f.d1);
    applyStimulus(f.d2);
    applyStimulus(f.d3);
    checkOutput({f.name, "_valid"}, 32'(o_valid), 32'd1);
    checkOutput({f.name, "_max"}, 32'(o_max), 32'(f.exp_max));
    checkOutput({f.name, "_idx"}, 32'(o_idx), 32'(f.exp_idx));
    @(posedge clk);
    #1;
    checkOutput({f.name, "_back_accept"}, {30'd0, i_ready, o_valid}, 32'b10);
  endtask

  function automatic frame_t mk(input string n, input int a, input int b, input int c, input int e,
                                input int m, input int ix);
    frame_t f;
    f.name = n;
    f.d0 = 8'(a); f.d1 = 8'(b); f.d2 = 8'(c); f.d3 = 8'(e);
    f.exp_max = 8'(m);
    f.exp_idx = 2'(ix);
    return f;
  endfunction

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
    v1 = 1'b0; d1 = '0; ordy1 = 1'b1;
    v4 = 1'b0; d4 = '0; ordy4 = 1'b1;

    frames[0] = mk("basic", 3, -5, 127, -128, 127, 2);
    frames[1] = mk("ovf", -128, -128, -1, -2, -1, 2);
    frames[2] = mk("tie", 5, 9, 9, 1, 9, TIE_LAST ? 2 : 1);
    frames[3] = mk("neg_tie", -3, -2, -9, -2, -2, TIE_LAST ? 3 : 1);
    frames[4] = mk("zeros", 0, 0, 0, 0, 0, TIE_LAST ? 3 : 0);
    frames[5] = mk("ramp", 1, 2, 3, 4, 4, 3);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_ready", 32'(i_ready), 32'd1);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_max", 32'(o_max), 32'd0);
    checkOutput("rst_idx", 32'(o_idx), 32'd0);

    for (int i = 0; i < 6; i++) runFrame(frames[i]);

    // Backpressure: held result stays put and the offered element is not swallowed.
    o_ready = 1'b0;
    applyStimulus(8'd10);
    applyStimulus(8'd20);
    applyStimulus(8'(-30));
    applyStimulus(8'd5);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'd99;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold", {13'd0, i_ready, o_valid, o_max, 8'd0, 6'd0, o_idx},
                  {13'd0, 1'b0, 1'b1, 8'd20, 8'd0, 6'd0, 2'd1});
      @(negedge clk);
    end
    o_ready = 1'b1;
    applyStimulus(8'd99);
    applyStimulus(8'(-1));
    applyStimulus(8'(-2));
    applyStimulus(8'(-3));
    checkOutput("bp_next_max", 32'(o_max), 32'd99);
    checkOutput("bp_next_idx", 32'(o_idx), 32'd0);
    @(posedge clk);
    #1;

    // Bubbles inside a complete frame.
    applyStimulus(8'(-50));
    repeat (2) @(negedge clk);
    applyStimulus(8'd100);
    repeat (3) @(negedge clk);
    applyStimulus(8'(-60));
    applyStimulus(8'd3);
    checkOutput("bubble_max", 32'(o_max), 32'd100);
    checkOutput("bubble_idx", 32'(o_idx), 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial result.
    applyStimulus(8'd60);
    repeat (2) @(negedge clk);
    applyStimulus(8'd70);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midrst_state", {14'd0, i_ready, o_valid, o_max, 6'd0, o_idx},
                {14'd0, 1'b1, 1'b0, 8'd0, 6'd0, 2'd0});
    runFrame(mk("after_rst", 7, -1, 8, 2, 8, 2));

    // Reset in DONE drops the pending result.
    o_ready = 1'b0;
    applyStimulus(8'd1);
    applyStimulus(8'd2);
    applyStimulus(8'd3);
    applyStimulus(8'd4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    o_ready = 1'b1;
    checkOutput("donerst_state", {14'd0, i_ready, o_valid, o_max, 6'd0, o_idx},
                {14'd0, 1'b1, 1'b0, 8'd0, 6'd0, 2'd0});

    // COUNT=1: every element is its own frame.
    @(negedge clk);
    v1 = 1'b1; d1 = 8'(-7);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    checkOutput("c1_first", {22'd0, ov1, max1, idx1}, {22'd0, 1'b1, 8'hF9, 1'b0});
    @(posedge clk);
    #1;
    checkOutput("c1_back", {30'd0, r1, ov1}, 32'b10);
    @(negedge clk);
    v1 = 1'b1; d1 = 8'd4;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    checkOutput("c1_second", {22'd0, ov1, max1, idx1}, {22'd0, 1'b1, 8'h04, 1'b0});
    @(posedge clk);
    #1;

    // Exhaustive WIDTH=4 compare sweep against signed integer arithmetic.
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        bit gt;
        gt = TIE_LAST ? (b >= a) : (b > a);
        @(negedge clk);
        v4 = 1'b1; d4 = 4'(a);
        @(posedge clk);
        #1;
        d4 = 4'(b);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        checkOutput($sformatf("sweep_%0d_%0d", a, b), {26'd0, ov4, max4, idx4},
                    {26'd0, 1'b1, 4'(gt ? b : a), gt});
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
